// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor.
//   state_t        : control FSM encoding (IDLE -> SHIFT -> DONE -> IDLE)
//   DEFAULT_WIDTH  : default operand/result width
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_fsub.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor cell computing x - y - bin. It mirrors the full
// adder cell used in the parallel datapath.
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in from the previous, less significant bit
//   d    : difference bit
//   bout : borrow out to the next, more significant bit
// Purely combinational.
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // A borrow is needed when the subtrahend side (y + bin) is larger than x.
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor computing diff = a - b (mod 2^WIDTH). It
// processes one bit per clock, LSB first. It uses a start/busy/done
// handshake, and the result is held until the next completed operation.
//
// Ports
//   clk         : rising-edge clock
//   rst_n       : synchronous active-low reset
//   start       : request, only honoured in IDLE
//   a, b        : minuend / subtrahend, captured on an accepted start
//   busy        : high while bits are being processed (WIDTH cycles)
//   done        : one-cycle pulse when diff/borrow_out are updated
//   diff        : a - b modulo 2^WIDTH
//   borrow_out  : 1 when a < b as unsigned values
//   ovf         : signed overflow flag (only with SERIAL_SUB_OVF_EN)
//
// Build option
//   SERIAL_SUB_OVF_EN : when defined, adds the ovf output. The operand MSBs
//                       are captured at start so that ovf can be computed.
//
// Timing: a start accepted at edge k gives busy during cycles k+1..k+WIDTH
// and done during cycle k+WIDTH+1. A new start can be accepted in the cycle
// after done, so one result is produced every WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;

    logic [CW-1:0]    r_cnt;        // index of the bit being processed
    logic [WIDTH-1:0] r_a_sr;       // minuend, shifted right each SHIFT cycle
    logic [WIDTH-1:0] r_b_sr;       // subtrahend, shifted right each SHIFT cycle
    logic [WIDTH-1:0] r_res_sr;     // partial result, filled from the MSB side
    logic             r_borrow;     // borrow between consecutive bits
    logic [WIDTH-1:0] r_diff;       // published result
    logic             r_borrow_out; // published final borrow

`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;      // sign of the captured minuend
    logic             r_b_msb;      // sign of the captured subtrahend
    logic             r_ovf;
`endif

    // FSM control strobes
    logic             w_load;       // accept start and capture operands
    logic             w_shift;      // process one bit
    logic             w_last;       // this SHIFT edge handles bit WIDTH-1

    // Cell outputs
    logic             w_d;
    logic             w_bout;

    // -------------------------------------------------------------------------
    // One subtractor cell. It always works on the current LSBs and the
    // stored borrow.
    // -------------------------------------------------------------------------
    full_subtractor u_fsub (
        .x    (r_a_sr[0]),
        .y    (r_b_sr[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and outputs. busy and done are decoded from the state
    // register only, so they are glitch-free and settle right after the edge.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end

            SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end

            DONE: begin
                // start is deliberately ignored here. The next request is
                // only seen once the FSM is back in IDLE.
                done         = 1'b1;
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res_sr     <= '0;
            r_borrow     <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else if (w_load) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_shift) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res_sr <= {w_d, r_res_sr[WIDTH-1:1]};
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + 1'b1;
            // The result is published only when complete. The value being
            // written to r_res_sr on this edge is copied straight into
            // r_diff, so partial results never appear on diff.
            if (w_last) begin
                r_diff       <= {w_d, r_res_sr[WIDTH-1:1]};
                r_borrow_out <= w_bout;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // -------------------------------------------------------------------------
    // Signed overflow. The operand MSBs have been shifted out of r_a_sr and
    // r_b_sr by the end of the operation, so they are kept separately. The
    // final difference bit w_d is the result MSB.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (w_shift && w_last) begin
            r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign ovf = r_ovf;
`endif

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed self-checking bench for serial_subtractor.
//   dut8 : WIDTH=8 instance for the directed scenarios
//   dut4 : WIDTH=4 instance for the full (a,b) sweep
// Define SERIAL_SUB_OVF_EN to include the ovf output and its checks.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bor8;
    logic [7:0] diff8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, bor4;
    logic [3:0] diff4;

`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf4;
`endif

    int checks   = 0;
    int failures = 0;
    int dcnt8    = 0;
    int dcnt4    = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bor8)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf        (ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (bor4)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf        (ovf4)
`endif
    );

    // Count done pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (done8 === 1'b1) dcnt8++;
        if (done4 === 1'b1) dcnt4++;
    end

    // Hard stop in case the sequence itself gets stuck.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one WIDTH=8 operation and check the handshake timing and the result.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [7:0] ed, input logic eb, input logic eo);
        int bc;
        int cyc;
        a8     = ta;
        b8     = tb_v;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        bc  = 0;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 === 1'b1) bc++;
            tick();
            cyc++;
        end
        check({tag, "_done"},    {31'd0, done8}, 32'd1);
        check({tag, "_latency"}, cyc,            32'd8);
        check({tag, "_busycyc"}, bc,             32'd8);
        check({tag, "_busy_at_done"}, {31'd0, busy8}, 32'd0);
        check({tag, "_diff"},    {24'd0, diff8}, {24'd0, ed});
        check({tag, "_borrow"},  {31'd0, bor8},  {31'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"},     {31'd0, ovf8},  {31'd0, eo});
`else
        if (eo) begin end
`endif
        $display("op %s a=%02h b=%02h diff=%02h borrow=%0b", tag, ta, tb_v, diff8, bor8);
        tick();
        check({tag, "_done_pulse"}, {31'd0, done8}, 32'd0);
        check({tag, "_diff_held"},  {24'd0, diff8}, {24'd0, ed});
    endtask

    initial begin
        int cyc;
        int d0;
        logic [3:0] va, vb, ed4;
        logic       eo4;

        rst_n  = 1'b0;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        tick();
        tick();

        // Reset state
        check("rst_busy",   {31'd0, busy8}, 32'd0);
        check("rst_done",   {31'd0, done8}, 32'd0);
        check("rst_diff",   {24'd0, diff8}, 32'd0);
        check("rst_borrow", {31'd0, bor8},  32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf",    {31'd0, ovf8},  32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Basic operations (expected results computed by hand)
        op8("basic",     8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
        op8("underflow", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        op8("signovf",   8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        // Start pulses while busy and during DONE must be ignored
        d0     = dcnt8;
        a8     = 8'h10;
        b8     = 8'h01;
        start8 = 1'b1;
        tick();                         // busy cycle 1
        start8 = 1'b0;
        tick();                         // busy cycle 2
        check("ign_diff_stable", {24'd0, diff8}, 32'h7F);
        tick();                         // busy cycle 3
        a8     = 8'hFF;
        b8     = 8'hFF;
        start8 = 1'b1;
        check("ign_busy_c3", {31'd0, busy8}, 32'd1);
        tick();
        start8 = 1'b0;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("ign_done",   {31'd0, done8}, 32'd1);
        check("ign_diff",   {24'd0, diff8}, 32'h0F);
        check("ign_borrow", {31'd0, bor8},  32'd0);
        start8 = 1'b1;                  // pulse during DONE
        tick();
        start8 = 1'b0;
        check("ign_idle_after_done", {31'd0, busy8}, 32'd0);
        tick();
        tick();
        check("ign_still_idle", {31'd0, busy8}, 32'd0);
        check("ign_one_done",   dcnt8 - d0,     32'd1);
        $display("op ignore a=10 b=01 diff=%02h borrow=%0b", diff8, bor8);

        // Reset during SHIFT discards the operation
        a8     = 8'h5A;
        b8     = 8'h3C;
        start8 = 1'b1;
        tick();                         // SHIFT cycle 1
        start8 = 1'b0;
        tick();
        tick();
        tick();                         // SHIFT cycle 4
        check("midrst_busy_before", {31'd0, busy8}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_busy",   {31'd0, busy8}, 32'd0);
        check("midrst_done",   {31'd0, done8}, 32'd0);
        check("midrst_diff",   {24'd0, diff8}, 32'd0);
        check("midrst_borrow", {31'd0, bor8},  32'd0);
        rst_n = 1'b1;
        tick();
        check("midrst_idle", {31'd0, busy8}, 32'd0);
        $display("op midreset diff=%02h borrow=%0b", diff8, bor8);
        op8("after_rst", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);

        // WIDTH=4 sweep over all pairs, issued back to back
        d0 = dcnt4;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                va     = ia[3:0];
                vb     = ib[3:0];
                ed4    = va - vb;
                eo4    = (va[3] != vb[3]) && (ed4[3] != va[3]);
                a4     = va;
                b4     = vb;
                start4 = 1'b1;
                tick();
                start4 = 1'b0;
                cyc = 0;
                while (done4 !== 1'b1 && cyc < 20) begin
                    tick();
                    cyc++;
                end
                check("sw_latency", cyc, 32'd4);
                check("sw_diff",   {28'd0, diff4}, {28'd0, ed4});
                check("sw_borrow", {31'd0, bor4},  {31'd0, (va < vb)});
`ifdef SERIAL_SUB_OVF_EN
                check("sw_ovf",    {31'd0, ovf4},  {31'd0, eo4});
`else
                if (eo4) begin end
`endif
                $display("op sweep a=%0h b=%0h diff=%0h borrow=%0b", va, vb, diff4, bor4);
                tick();                 // DONE -> IDLE
            end
        end
        tick();
        check("sw_done_count", dcnt4 - d0, 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_subtractor
